// File: rtl/debug_exception_ctrl.sv
// debug_exception_ctrl
// Consumer side of the write-stage debug trigger interface. Captures the
// breakpoint/step/task flags one cycle after wr_debug_prepare (or a general
// detect fault from the DRx-move path), raises a #DB request to the exception
// unit, holds it until acknowledged or aborted, then commits DR6 and pulses
// wr_debug_trap_clear back to the trigger logic.
module debug_exception_ctrl #(
    parameter logic [7:0]  EXC_VECTOR    = 8'd1,
    parameter logic [31:0] DR6_RSVD_ONES = 32'hFFFF0FF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_debug_prepare,
    input  logic [3:0]  wr_debug_code_reg,
    input  logic [3:0]  wr_debug_write_reg,
    input  logic [3:0]  wr_debug_read_reg,
    input  logic        wr_debug_step_reg,
    input  logic        wr_debug_task_reg,
    input  logic        gd_trigger,
    input  logic [31:0] dr6,
    input  logic        exc_ack,
    input  logic        exc_abort,
    output logic        exc_req,
    output logic [7:0]  exc_vector,
    output logic        dr6_write,
    output logic [31:0] dr6_next,
    output logic        wr_debug_trap_clear,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REQ     = 2'd2,
        ST_UPDATE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;

    // Captured debug cause: B0..B3 hits, general detect, single step, task switch
    logic [3:0]  b_r;
    logic [3:0]  b_s;
    logic        bd_r;
    logic        bd_s;
    logic        bs_r;
    logic        bs_s;
    logic        bt_r;
    logic        bt_s;

    // Registered output copies, loaded from the next state
    logic        exc_req_r;
    logic [7:0]  exc_vector_r;
    logic        dr6_write_r;
    logic        trap_clear_r;
    logic        busy_r;

    // Merge the captured cause into the current DR6: B bits are overwritten,
    // BD/BS/BT are sticky, bit 12 is cleared and reserved bits read as one.
    function automatic logic [31:0] compose_dr6(
        input logic [31:0] cur,
        input logic [3:0]  b,
        input logic        bd,
        input logic        bs,
        input logic        bt
    );
        logic [31:0] val;
        val        = cur;
        val[3:0]   = b;
        val[12]    = 1'b0;
        val[13]    = cur[13] | bd;
        val[14]    = cur[14] | bs;
        val[15]    = cur[15] | bt;
        return val | DR6_RSVD_ONES;
    endfunction

    // Next-state and flag-capture logic
    always_comb begin
        state_s = state_r;
        b_s     = b_r;
        bd_s    = bd_r;
        bs_s    = bs_r;
        bt_s    = bt_r;
        case (state_r)
            ST_IDLE: begin
                if (wr_debug_prepare) begin
                    // Flags arrive next cycle; a coincident GD fault is kept as BD
                    state_s = ST_CAPTURE;
                    b_s     = 4'b0000;
                    bd_s    = gd_trigger;
                    bs_s    = 1'b0;
                    bt_s    = 1'b0;
                end else if (gd_trigger) begin
                    // GD fault has no breakpoint flags to wait for
                    state_s = ST_REQ;
                    b_s     = 4'b0000;
                    bd_s    = 1'b1;
                    bs_s    = 1'b0;
                    bt_s    = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_s = ST_REQ;
                b_s     = wr_debug_code_reg | wr_debug_write_reg | wr_debug_read_reg;
                bs_s    = wr_debug_step_reg;
                bt_s    = wr_debug_task_reg;
                bd_s    = bd_r;
            end
            ST_REQ: begin
                // A flush outranks a same-cycle acknowledge
                if (exc_abort) begin
                    state_s = ST_IDLE;
                end else if (exc_ack) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_UPDATE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured flags and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            b_r          <= 4'b0000;
            bd_r         <= 1'b0;
            bs_r         <= 1'b0;
            bt_r         <= 1'b0;
            exc_req_r    <= 1'b0;
            exc_vector_r <= 8'd0;
            dr6_write_r  <= 1'b0;
            trap_clear_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            b_r          <= b_s;
            bd_r         <= bd_s;
            bs_r         <= bs_s;
            bt_r         <= bt_s;
            exc_req_r    <= (state_s == ST_REQ);
            exc_vector_r <= (state_s == ST_REQ) ? EXC_VECTOR : 8'd0;
            dr6_write_r  <= (state_s == ST_UPDATE);
            trap_clear_r <= (state_s == ST_UPDATE);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // DR6 is read live during the update cycle so a write by the exception
    // unit while the request was pending is preserved.
    always_comb begin
        dr6_next = 32'h0000_0000;
        if (dr6_write_r) begin
            dr6_next = compose_dr6(dr6, b_r, bd_r, bs_r, bt_r);
        end else begin
            dr6_next = 32'h0000_0000;
        end
    end

    assign exc_req             = exc_req_r;
    assign exc_vector          = exc_vector_r;
    assign dr6_write           = dr6_write_r;
    assign wr_debug_trap_clear = trap_clear_r;
    assign busy                = busy_r;

endmodule

// File: tb/tb_debug_exception_ctrl.sv
// Testbench for debug_exception_ctrl: directed scenarios plus randomized
// transactions, each checked against a transaction-level timeline model.
module tb_debug_exception_ctrl;

    localparam logic [31:0] RSVD = 32'hFFFF0FF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_debug_prepare;
    logic [3:0]  wr_debug_code_reg;
    logic [3:0]  wr_debug_write_reg;
    logic [3:0]  wr_debug_read_reg;
    logic        wr_debug_step_reg;
    logic        wr_debug_task_reg;
    logic        gd_trigger;
    logic [31:0] dr6;
    logic        exc_ack;
    logic        exc_abort;
    logic        exc_req;
    logic [7:0]  exc_vector;
    logic        dr6_write;
    logic [31:0] dr6_next;
    logic        wr_debug_trap_clear;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    debug_exception_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .wr_debug_prepare    (wr_debug_prepare),
        .wr_debug_code_reg   (wr_debug_code_reg),
        .wr_debug_write_reg  (wr_debug_write_reg),
        .wr_debug_read_reg   (wr_debug_read_reg),
        .wr_debug_step_reg   (wr_debug_step_reg),
        .wr_debug_task_reg   (wr_debug_task_reg),
        .gd_trigger          (gd_trigger),
        .dr6                 (dr6),
        .exc_ack             (exc_ack),
        .exc_abort           (exc_abort),
        .exc_req             (exc_req),
        .exc_vector          (exc_vector),
        .dr6_write           (dr6_write),
        .dr6_next            (dr6_next),
        .wr_debug_trap_clear (wr_debug_trap_clear),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_flags();
        wr_debug_code_reg  = 4'($urandom);
        wr_debug_write_reg = 4'($urandom);
        wr_debug_read_reg  = 4'($urandom);
        wr_debug_step_reg  = 1'($urandom);
        wr_debug_task_reg  = 1'($urandom);
    endtask

    // Expected DR6 after a debug event, straight from the architectural rules
    function automatic logic [31:0] model_dr6(input logic [31:0] cur, input logic [3:0] b,
                                              input logic bd, input logic bs, input logic bt);
        logic [31:0] r;
        r = (cur & ~32'h0000_F00F) | {16'h0000, cur[15] | bt, cur[14] | bs, cur[13] | bd, 13'h0000} | {28'h0000000, b};
        return r | RSVD;
    endfunction

    // One full debug transaction. kind: 0 = prepare, 1 = GD only, 2 = prepare+GD
    task automatic run_txn(input string nm, input int kind,
                           input logic [3:0] code, input logic [3:0] wr, input logic [3:0] rd,
                           input logic stp, input logic tsk, input logic [31:0] d6,
                           input int ack_dly, input bit abrt);
        logic [3:0]  eb;
        logic        ebd;
        logic        ebs;
        logic        ebt;
        logic [31:0] exp_dr6;
        ebd     = (kind != 0);
        eb      = (kind == 1) ? 4'h0 : (code | wr | rd);
        ebs     = (kind == 1) ? 1'b0 : stp;
        ebt     = (kind == 1) ? 1'b0 : tsk;
        exp_dr6 = model_dr6(d6, eb, ebd, ebs, ebt);

        n_checks++;
        if (busy !== 1'b0 || exc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_before: busy=%b exc_req=%b want 0 0", nm, busy, exc_req);
        end
        wr_debug_prepare = (kind != 1);
        gd_trigger       = (kind != 0);
        junk_flags();
        tick();
        wr_debug_prepare = 1'b0;
        gd_trigger       = 1'b0;
        if (kind != 1) begin
            wr_debug_code_reg  = code;
            wr_debug_write_reg = wr;
            wr_debug_read_reg  = rd;
            wr_debug_step_reg  = stp;
            wr_debug_task_reg  = tsk;
            n_checks++;
            if (busy !== 1'b1 || exc_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s capture: busy=%b exc_req=%b want 1 0", nm, busy, exc_req);
            end
            tick();
        end
        junk_flags();
        for (int d = 0; d <= ack_dly; d++) begin
            n_checks++;
            if (exc_req !== 1'b1 || exc_vector !== 8'd1 || dr6_write !== 1'b0 ||
                wr_debug_trap_clear !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s req[%0d]: req=%b vec=%0d wr=%b clr=%b busy=%b want 1 1 0 0 1",
                         nm, d, exc_req, exc_vector, dr6_write, wr_debug_trap_clear, busy);
            end
            dr6 = $urandom;
            if (d == ack_dly) begin
                exc_ack          = 1'b1;
                exc_abort        = abrt;
                wr_debug_prepare = 1'b0;
                gd_trigger       = 1'b0;
            end else begin
                exc_ack          = 1'b0;
                exc_abort        = 1'b0;
                wr_debug_prepare = 1'($urandom);
                gd_trigger       = 1'($urandom);
            end
            tick();
        end
        wr_debug_prepare = 1'b0;
        gd_trigger       = 1'b0;
        exc_ack          = 1'($urandom);
        exc_abort        = 1'($urandom);
        dr6              = d6;
        #1;
        n_checks++;
        if (!abrt) begin
            if (dr6_write !== 1'b1 || wr_debug_trap_clear !== 1'b1 || dr6_next !== exp_dr6 ||
                exc_req !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s update: wr=%b clr=%b dr6_next=%h req=%b busy=%b want 1 1 %h 0 1",
                         nm, dr6_write, wr_debug_trap_clear, dr6_next, exc_req, busy, exp_dr6);
            end
        end else begin
            if (dr6_write !== 1'b0 || wr_debug_trap_clear !== 1'b0 || exc_req !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s abort: wr=%b clr=%b req=%b busy=%b want 0 0 0 0",
                         nm, dr6_write, wr_debug_trap_clear, exc_req, busy);
            end
        end
        tick();
        exc_ack   = 1'b0;
        exc_abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dr6_write !== 1'b0 || wr_debug_trap_clear !== 1'b0 || exc_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after: busy=%b wr=%b clr=%b req=%b want 0 0 0 0",
                     nm, busy, dr6_write, wr_debug_trap_clear, exc_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_debug_prepare = 1'b1;
        gd_trigger       = 1'b1;
        exc_ack          = 1'b1;
        exc_abort        = 1'b0;
        dr6              = 32'hFFFF0FF0;
        junk_flags();
        tick();
        tick();
        n_checks++;
        if (exc_req !== 1'b0 || exc_vector !== 8'd0 || dr6_write !== 1'b0 || dr6_next !== 32'h0 ||
            wr_debug_trap_clear !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: req=%b vec=%0d wr=%b next=%h clr=%b busy=%b want all 0",
                     exc_req, exc_vector, dr6_write, dr6_next, wr_debug_trap_clear, busy);
        end
        rst = 1'b0;
        wr_debug_prepare = 1'b0;
        gd_trigger       = 1'b0;
        exc_ack          = 1'b0;
        tick();
    endtask

    task automatic test_code_bp();
        run_txn("code_bp", 0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hFFFF0FF0, 2, 1'b0);
    endtask

    task automatic test_step_write();
        run_txn("step_write", 0, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 32'hFFFF2FF0, 1, 1'b0);
    endtask

    task automatic test_gd();
        run_txn("gd", 1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hFFFF0FF0, 0, 1'b0);
    endtask

    task automatic test_gd_with_prepare();
        run_txn("gd_prep", 2, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'hFFFF0FF0, 0, 1'b0);
    endtask

    task automatic test_task_read();
        run_txn("task_read", 0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 32'hFFFF0FFF, 3, 1'b0);
    endtask

    task automatic test_abort();
        run_txn("abort", 0, 4'b0011, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'hFFFF0FF0, 1, 1'b1);
    endtask

    task automatic test_reset_in_req();
        wr_debug_prepare = 1'b1;
        tick();
        wr_debug_prepare  = 1'b0;
        wr_debug_code_reg = 4'b0001;
        tick();
        n_checks++;
        if (exc_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_req_pre: exc_req=%b want 1", exc_req);
        end
        rst     = 1'b1;
        exc_ack = 1'b1;
        tick();
        rst     = 1'b0;
        exc_ack = 1'b0;
        n_checks++;
        if (exc_req !== 1'b0 || busy !== 1'b0 || dr6_write !== 1'b0 || wr_debug_trap_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_post: req=%b busy=%b wr=%b clr=%b want 0 0 0 0",
                     exc_req, busy, dr6_write, wr_debug_trap_clear);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || dr6_write !== 1'b0 || wr_debug_trap_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_quiet: busy=%b wr=%b clr=%b want 0 0 0", busy, dr6_write, wr_debug_trap_clear);
        end
        run_txn("after_rst", 0, 4'b1000, 4'b0100, 4'b0000, 1'b0, 1'b0, 32'hFFFF0FF0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn("random", int'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) begin
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_debug_prepare = 1'b0;
        gd_trigger = 1'b0;
        exc_ack = 1'b0;
        exc_abort = 1'b0;
        dr6 = 32'h0;
        wr_debug_code_reg = 4'h0;
        wr_debug_write_reg = 4'h0;
        wr_debug_read_reg = 4'h0;
        wr_debug_step_reg = 1'b0;
        wr_debug_task_reg = 1'b0;
        test_reset();
        test_code_bp();
        test_step_write();
        test_gd();
        test_gd_with_prepare();
        test_task_read();
        test_abort();
        test_reset_in_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
